throw_ctrl: RTL and testbench
=============================

# throw_ctrl

Turn and throw sequencer for the two-player cat-and-dog game. It tracks whose turn it is and charges throw power while the local player holds the throw button. It launches a throw for the local or the remote player and waits for the projectile engine to report the end of flight. Its `current_player`, `turn`, `throw_flag` and `left` outputs feed the LED status stage directly, and `power` goes to the projectile engine.

## Interface
- `POWER_W`, 7: width of the throw power value.
- `STEP_CYC`, 600000: cycles per power increment while charging (10 ms at 60 MHz).
- `FLIGHT_TIMEOUT`, 180000000: maximum cycles in flight before the turn is forced to end (3 s).
- `clk60MHz` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `sw_player` in 1: local player select (0 = cat, left side; 1 = dog, right side).
- `btn_throw` in 1: debounced, clock-synchronous throw button level.
- `remote_throw` in 1: one-cycle pulse from the link; the peer launched a throw.
- `remote_power` in POWER_W: peer throw power, valid with `remote_throw`.
- `throw_done` in 1: one-cycle pulse from the projectile engine; flight ended (hit or miss).
- `current_player` out 1: registered local player identity.
- `turn` out 1: player whose turn it is (0 = cat, 1 = dog).
- `throw_flag` out 1: high for the whole flight.
- `left` out 1: flight direction; 1 = projectile travels leftward.
- `power` out POWER_W: power of the current or last throw.

## Operation
- The FSM has four states: WAIT, AIM, CHARGE, FLIGHT.
- Reset state:
  - `turn` = 0, `throw_flag` = 0, `left` = 0, `power` = 0.
  - The step counter and timeout counter are 0.
  - `current_player` = `sw_player` sampled on the reset cycle.
  - The next state is AIM if `current_player` == 0, otherwise WAIT.
- `current_player` re-samples `sw_player` only in WAIT and AIM. Changes during CHARGE or FLIGHT are ignored until the block returns to WAIT or AIM.
- WAIT (remote player's turn):
  - `remote_throw` loads `power` ← `remote_power`, sets `throw_flag` = 1 and `left` = `turn`, then goes to FLIGHT.
  - `btn_throw` is ignored.
- AIM (local player's turn):
  - A rising edge of `btn_throw` (detected against a registered copy) clears `power` and the step counter, then goes to CHARGE.
  - A button already held on entry to AIM does not start a charge until it is released and pressed again.
- CHARGE:
  - The step counter counts to STEP_CYC−1, then wraps. On each wrap, `power` increments and saturates at 2^POWER_W−1.
  - When `btn_throw` = 0, it sets `throw_flag` = 1 and `left` = `turn`, holds `power`, then goes to FLIGHT.
- FLIGHT:
  - `throw_flag` stays 1 and the timeout counter increments.
  - `throw_done` or timeout counter = FLIGHT_TIMEOUT−1 does all of the following: clears `throw_flag`, toggles `turn`, clears the timeout counter, and goes to AIM if the new `turn` == `current_player`, otherwise WAIT.
  - `power` and `left` hold their values after the flight.
- `remote_throw` outside WAIT is dropped.
- `throw_done` outside FLIGHT is dropped.
- If `throw_done` and the timeout coincide, the turn ends exactly once (`turn` toggles once).
- `rst` during any state, including mid-charge or mid-flight, returns all outputs to their reset values on the next edge.

## Timing
- All outputs are registered and change only on the `clk60MHz` rising edge.
- Press to CHARGE: the rising edge is detected in the cycle `btn_throw` is first sampled high. The state becomes CHARGE at the following edge.
- Release to launch: `throw_flag` = 1 one cycle after the first cycle `btn_throw` is sampled low in CHARGE.
- Remote launch: `throw_flag` = 1 and `power` = `remote_power` one cycle after the `remote_throw` cycle.
- Turn end: `throw_flag` = 0 and `turn` toggled one cycle after the `throw_done` cycle. The new state is AIM or WAIT in that same cycle.
- Power growth: the first increment happens STEP_CYC cycles after entry to CHARGE. A full ramp takes (2^POWER_W−1)·STEP_CYC cycles.

## Test plan
All scenarios use STEP_CYC = 4, FLIGHT_TIMEOUT = 50, POWER_W = 7.

1. Local throw: reset with `sw_player` = 0, press `btn_throw` for 20 cycles, release → `power` = 5, `throw_flag` = 1, `left` = 0, `turn` = 0. Then pulse `throw_done` → next cycle `throw_flag` = 0, `turn` = 1, state WAIT.
2. Remote throw: in WAIT with `turn` = 1, pulse `remote_throw` with `remote_power` = 42 → next cycle `power` = 42, `throw_flag` = 1, `left` = 1. Then `throw_done` → `turn` = 0, state AIM.
3. Saturation: hold `btn_throw` for 600 cycles → `power` = 127 and stays there. On release, launch with 127.
4. Timeout: launch a throw and never pulse `throw_done` → `throw_flag` drops exactly 50 cycles after launch and `turn` toggles once.
5. Ignored inputs:
   - `btn_throw` pulses in WAIT, `remote_throw` in AIM, and `throw_done` in AIM → no state or output change.
   - Button held on entry to AIM → no CHARGE until it is released and pressed again.
6. Reset mid-operation: assert `rst` in CHARGE and in FLIGHT → next cycle `throw_flag` = 0, `power` = 0, `turn` = 0, `left` = 0, state AIM/WAIT per `sw_player`.

Source files
------------

// File: rtl/throw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : throw_ctrl
// Function : Turn and throw sequencer for the cat-and-dog game. Tracks whose
//            turn it is, charges throw power while the local button is held,
//            launches local or remote throws and waits for the end of flight.
// Revision : 1.0 - initial release
// ============================================================================
module throw_ctrl #(
   parameter int POWER_W        = 7,
   parameter int STEP_CYC       = 600000,
   parameter int FLIGHT_TIMEOUT = 180000000
) (
   input  logic               clk60MHz,
   input  logic               rst,
   input  logic               sw_player,
   input  logic               btn_throw,
   input  logic               remote_throw,
   input  logic [POWER_W-1:0] remote_power,
   input  logic               throw_done,
   output logic               current_player,
   output logic               turn,
   output logic               throw_flag,
   output logic               left,
   output logic [POWER_W-1:0] power
);

   localparam int c_step_w = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam int c_tmo_w  = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;
   localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_CYC - 1);
   localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(FLIGHT_TIMEOUT - 1);
   localparam logic [POWER_W-1:0]  c_power_max = '1;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_AIM    = 2'd1,
      ST_CHARGE = 2'd2,
      ST_FLIGHT = 2'd3
   } state_t;

   state_t               r_state,  w_state_nxt;
   logic                 r_player, w_player_nxt;
   logic                 r_turn,   w_turn_nxt;
   logic                 r_flag,   w_flag_nxt;
   logic                 r_left,   w_left_nxt;
   logic [POWER_W-1:0]   r_power,  w_power_nxt;
   logic [c_step_w-1:0]  r_step,   w_step_nxt;
   logic [c_tmo_w-1:0]   r_tmo,    w_tmo_nxt;
   logic                 r_btn_q;
   logic                 w_btn_rise;

   // A press only counts when the previous sample was low, so a button
   // already held when AIM is entered must be released first.
   assign w_btn_rise = btn_throw & ~r_btn_q;

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      w_state_nxt  = r_state;
      w_player_nxt = r_player;
      w_turn_nxt   = r_turn;
      w_flag_nxt   = r_flag;
      w_left_nxt   = r_left;
      w_power_nxt  = r_power;
      w_step_nxt   = r_step;
      w_tmo_nxt    = r_tmo;
      case (r_state)
         ST_WAIT: begin
            w_player_nxt = sw_player;
            if (remote_throw) begin
               w_power_nxt = remote_power;
               w_flag_nxt  = 1'b1;
               w_left_nxt  = r_turn;
               w_state_nxt = ST_FLIGHT;
            end
         end
         ST_AIM: begin
            w_player_nxt = sw_player;
            if (w_btn_rise) begin
               w_power_nxt = '0;
               w_step_nxt  = '0;
               w_state_nxt = ST_CHARGE;
            end
         end
         ST_CHARGE: begin
            if (!btn_throw) begin
               w_flag_nxt  = 1'b1;
               w_left_nxt  = r_turn;
               w_state_nxt = ST_FLIGHT;
            end else if (r_step == c_step_last) begin
               w_step_nxt = '0;
               if (r_power != c_power_max) begin
                  w_power_nxt = r_power + 1'b1;
               end
            end else begin
               w_step_nxt = r_step + 1'b1;
            end
         end
         ST_FLIGHT: begin
            // Done pulse and timeout share one branch, so a coincidence
            // still ends the turn only once.
            if (throw_done || (r_tmo == c_tmo_last)) begin
               w_flag_nxt  = 1'b0;
               w_turn_nxt  = ~r_turn;
               w_tmo_nxt   = '0;
               w_state_nxt = ((~r_turn) == r_player) ? ST_AIM : ST_WAIT;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         default: w_state_nxt = ST_WAIT;
      endcase
   end

   // State and output registers; reset picks the starting state from the switch.
   always_ff @(posedge clk60MHz) begin
      r_btn_q <= btn_throw;
      if (rst) begin
         r_state  <= sw_player ? ST_WAIT : ST_AIM;
         r_player <= sw_player;
         r_turn   <= 1'b0;
         r_flag   <= 1'b0;
         r_left   <= 1'b0;
         r_power  <= '0;
         r_step   <= '0;
         r_tmo    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_player <= w_player_nxt;
         r_turn   <= w_turn_nxt;
         r_flag   <= w_flag_nxt;
         r_left   <= w_left_nxt;
         r_power  <= w_power_nxt;
         r_step   <= w_step_nxt;
         r_tmo    <= w_tmo_nxt;
      end
   end

   assign current_player = r_player;
   assign turn           = r_turn;
   assign throw_flag     = r_flag;
   assign left           = r_left;
   assign power          = r_power;

endmodule
`default_nettype wire

// File: tb/tb_throw_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_throw_ctrl
// Function : Self-checking bench for throw_ctrl: directed game scenarios plus
//            a randomized phase, all compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_throw_ctrl;

   localparam int POWER_W        = 7;
   localparam int STEP_CYC       = 4;
   localparam int FLIGHT_TIMEOUT = 50;
   localparam int PMAX           = (1 << POWER_W) - 1;

   logic               clk60MHz = 1'b0;
   logic               rst = 1'b1;
   logic               sw_player = 1'b0;
   logic               btn_throw = 1'b0;
   logic               remote_throw = 1'b0;
   logic [POWER_W-1:0] remote_power = '0;
   logic               throw_done = 1'b0;
   logic               current_player;
   logic               turn;
   logic               throw_flag;
   logic               left;
   logic [POWER_W-1:0] power;

   throw_ctrl #(
      .POWER_W        (POWER_W),
      .STEP_CYC       (STEP_CYC),
      .FLIGHT_TIMEOUT (FLIGHT_TIMEOUT)
   ) u_dut (
      .clk60MHz       (clk60MHz),
      .rst            (rst),
      .sw_player      (sw_player),
      .btn_throw      (btn_throw),
      .remote_throw   (remote_throw),
      .remote_power   (remote_power),
      .throw_done     (throw_done),
      .current_player (current_player),
      .turn           (turn),
      .throw_flag     (throw_flag),
      .left           (left),
      .power          (power)
   );

   // Free-running clock.
   always #5 clk60MHz = ~clk60MHz;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: the game expressed as "is a flight in progress",
   // "is the local player charging" and elapsed-cycle counts.
   int m_player = 0, m_turn = 0, m_flag = 0, m_left = 0, m_power = 0;
   int m_charge_cyc = 0, m_flight_cyc = 0;
   bit m_charging = 1'b0;
   bit m_btn_q = 1'b0;

   task automatic model_step();
      if (rst) begin
         m_player = int'(sw_player);
         m_turn = 0; m_flag = 0; m_left = 0; m_power = 0;
         m_charging = 1'b0; m_charge_cyc = 0; m_flight_cyc = 0;
      end else if (m_flag != 0) begin
         m_flight_cyc++;
         if (throw_done || m_flight_cyc == FLIGHT_TIMEOUT) begin
            m_flag = 0;
            m_turn = 1 - m_turn;
            m_flight_cyc = 0;
         end
      end else if (m_charging) begin
         if (!btn_throw) begin
            m_charging = 1'b0;
            m_flag = 1;
            m_left = m_turn;
            m_flight_cyc = 0;
         end else begin
            m_charge_cyc++;
            m_power = (m_charge_cyc / STEP_CYC > PMAX) ? PMAX : m_charge_cyc / STEP_CYC;
         end
      end else begin
         if (m_turn == m_player) begin
            if (btn_throw && !m_btn_q) begin
               m_charging = 1'b1;
               m_charge_cyc = 0;
               m_power = 0;
            end
         end else if (remote_throw) begin
            m_power = int'(remote_power);
            m_flag = 1;
            m_left = m_turn;
            m_flight_cyc = 0;
         end
         m_player = int'(sw_player);
      end
      m_btn_q = btn_throw;
   endtask

   task automatic tick();
      @(posedge clk60MHz);
      model_step();
      #1;
      chk("m_flag",   32'(throw_flag),     32'(m_flag));
      chk("m_turn",   32'(turn),           32'(m_turn));
      chk("m_left",   32'(left),           32'(m_left));
      chk("m_power",  32'(power),          32'(m_power));
      chk("m_player", 32'(current_player), 32'(m_player));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_remote(input int pw);
      remote_power = POWER_W'(pw);
      remote_throw = 1'b1;
      tick();
      remote_throw = 1'b0;
   endtask

   task automatic pulse_done();
      throw_done = 1'b1;
      tick();
      throw_done = 1'b0;
   endtask

   initial begin
      int n;
      // Reset with the cat selected.
      ticks(2);
      chk("rst_flag",   32'(throw_flag), 0);
      chk("rst_turn",   32'(turn), 0);
      chk("rst_left",   32'(left), 0);
      chk("rst_power",  32'(power), 0);
      chk("rst_player", 32'(current_player), 0);
      rst = 1'b0;
      tick();

      // Local throw: 20 charging cycles after the press edge give power 5.
      btn_throw = 1'b1;
      ticks(21);
      btn_throw = 1'b0;
      tick();
      chk("s1_power", 32'(power), 5);
      chk("s1_flag",  32'(throw_flag), 1);
      chk("s1_left",  32'(left), 0);
      chk("s1_turn",  32'(turn), 0);
      ticks(3);
      pulse_done();
      chk("s1_end_flag", 32'(throw_flag), 0);
      chk("s1_end_turn", 32'(turn), 1);

      // Remote player's turn: button and done pulses do nothing.
      btn_throw = 1'b1; tick(); btn_throw = 1'b0; tick();
      btn_throw = 1'b1; tick(); btn_throw = 1'b0;
      pulse_done();
      ticks(2);
      chk("s5w_flag",  32'(throw_flag), 0);
      chk("s5w_power", 32'(power), 5);
      chk("s5w_turn",  32'(turn), 1);

      // Remote throw of 42, button held through the flight into AIM.
      pulse_remote(42);
      chk("s2_power", 32'(power), 42);
      chk("s2_flag",  32'(throw_flag), 1);
      chk("s2_left",  32'(left), 1);
      btn_throw = 1'b1;
      ticks(2);
      pulse_done();
      chk("s2_turn", 32'(turn), 0);
      chk("s2_flag_end", 32'(throw_flag), 0);
      ticks(10);
      chk("s5_held_power", 32'(power), 42);
      pulse_remote(7);
      pulse_done();
      tick();
      chk("s5a_power", 32'(power), 42);
      chk("s5a_flag",  32'(throw_flag), 0);
      chk("s5a_turn",  32'(turn), 0);

      // Release then press again: charge starts, then saturates.
      btn_throw = 1'b0;
      ticks(2);
      btn_throw = 1'b1;
      ticks(2);
      chk("s5_repress_power", 32'(power), 0);
      ticks(600);
      chk("s3_sat", 32'(power), PMAX);
      ticks(20);
      chk("s3_sat_hold", 32'(power), PMAX);
      btn_throw = 1'b0;
      tick();
      chk("s3_launch_flag",  32'(throw_flag), 1);
      chk("s3_launch_power", 32'(power), PMAX);

      // Timeout: no done pulse, the flight must last exactly 50 cycles.
      n = 0;
      while (throw_flag && n < 200) begin
         tick();
         n++;
      end
      chk("s4_len", 32'(n), FLIGHT_TIMEOUT);
      chk("s4_turn", 32'(turn), 1);
      ticks(5);
      chk("s4_turn_once", 32'(turn), 1);

      // Reset mid-flight with the dog selected.
      pulse_remote(99);
      ticks(3);
      sw_player = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s6f_flag",   32'(throw_flag), 0);
      chk("s6f_power",  32'(power), 0);
      chk("s6f_turn",   32'(turn), 0);
      chk("s6f_left",   32'(left), 0);
      chk("s6f_player", 32'(current_player), 1);

      // Reset mid-charge with the cat selected.
      pulse_remote(11);
      pulse_done();
      btn_throw = 1'b1;
      ticks(9);
      chk("s6c_charging", 32'(power), 2);
      sw_player = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      btn_throw = 1'b0;
      chk("s6c_flag",   32'(throw_flag), 0);
      chk("s6c_power",  32'(power), 0);
      chk("s6c_turn",   32'(turn), 0);
      chk("s6c_player", 32'(current_player), 0);

      // Randomized play against the model.
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         if (rst) sw_player = 1'($urandom_range(0, 1));
         remote_throw = ($urandom_range(0, 29) == 0);
         remote_power = POWER_W'($urandom);
         throw_done   = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 14) == 0) btn_throw = ~btn_throw;
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
